// File: rtl/fir_guide_pkg.sv
// Shared constants for the 16-tap symmetric FIR.
// Coefficient table holds h[0..7]; h[k] = h[15-k] supplies the rest.
package fir_guide_pkg;

  localparam int NTAPS  = 16;
  localparam int NHALF  = 8;
  localparam int IN_W   = 12;
  localparam int COEF_W = 12;
  localparam int SUM_W  = 13;
  localparam int PROD_W = 25;
  localparam int OUT_W  = 29;

  typedef logic [COEF_W-1:0] coef_t;

  localparam coef_t COEF [NHALF] = '{
    12'd11,  12'd31,  12'd63,  12'd104,
    12'd152, 12'd198, 12'd235, 12'd255
  };

  function automatic coef_t coef_at(input int k);
    return (k < NHALF) ? COEF[k] : COEF[NTAPS-1-k];
  endfunction

endpackage

// File: rtl/fir_guide_mult.sv
// Registered unsigned multiplier, async active-high reset.
module fir_guide_mult #(
  parameter int A_W = 13,
  parameter int B_W = 12
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [A_W-1:0]     i_a,
  input  logic [B_W-1:0]     i_b,
  output logic [A_W+B_W-1:0] o_p
);

  localparam int P_W = A_W + B_W;

  logic [P_W-1:0] r_p;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_p <= '0;
    else     r_p <= P_W'(i_a) * P_W'(i_b);
  end

  assign o_p = r_p;

endmodule

// File: rtl/fir_guide.sv
// 16-tap linear-phase FIR, 3-stage pipeline behind the tap register.
// FIR_PREADD_EN selects the symmetric pre-adder (8 multipliers).
module fir_guide
  import fir_guide_pkg::*;
(
  input  logic             clk,
  input  logic             rstn,
  input  logic             en,
  input  logic [IN_W-1:0]  xin,
  output logic             valid,
  output logic [OUT_W-1:0] yout
);

`ifdef FIR_PREADD_EN
  localparam int NMUL = NHALF;
  localparam int A_W  = SUM_W;
  localparam int P_W  = PROD_W;
`else
  localparam int NMUL = NTAPS;
  localparam int A_W  = IN_W;
  localparam int P_W  = IN_W + COEF_W;
`endif

  logic [IN_W-1:0]  r_tap [NTAPS];
  logic [A_W-1:0]   r_s1  [NMUL];
  logic [P_W-1:0]   w_prod[NMUL];
  logic [OUT_W-1:0] w_sum;
  logic [OUT_W-1:0] r_y;
  logic             r_tap_en;
  logic [2:0]       r_vld;

  always_ff @(posedge clk or posedge rstn) begin
    if (rstn) begin
      for (int i = 0; i < NTAPS; i++) r_tap[i] <= '0;
    end else if (en) begin
      r_tap[0] <= xin;
      for (int i = 1; i < NTAPS; i++) r_tap[i] <= r_tap[i-1];
    end
  end

  always_ff @(posedge clk or posedge rstn) begin
    if (rstn) begin
      for (int i = 0; i < NMUL; i++) r_s1[i] <= '0;
    end else begin
      for (int i = 0; i < NMUL; i++) begin
`ifdef FIR_PREADD_EN
        r_s1[i] <= SUM_W'(r_tap[i]) + SUM_W'(r_tap[NTAPS-1-i]);
`else
        r_s1[i] <= r_tap[i];
`endif
      end
    end
  end

  for (genvar k = 0; k < NMUL; k++) begin : g_mul
    localparam coef_t C = coef_at(k);
    fir_guide_mult #(
      .A_W(A_W),
      .B_W(COEF_W)
    ) u_mult (
      .clk(clk),
      .rst(rstn),
      .i_a(r_s1[k]),
      .i_b(C),
      .o_p(w_prod[k])
    );
  end

  always_comb begin
    w_sum = '0;
    for (int i = 0; i < NMUL; i++) w_sum = w_sum + OUT_W'(w_prod[i]);
  end

  // r_tap_en marks the tap stage; r_vld follows the data through stages 1-3
  always_ff @(posedge clk or posedge rstn) begin
    if (rstn) begin
      r_y      <= '0;
      r_tap_en <= 1'b0;
      r_vld    <= '0;
    end else begin
      r_y      <= w_sum;
      r_tap_en <= en;
      r_vld    <= {r_vld[1:0], r_tap_en};
    end
  end

  assign yout  = r_y;
  assign valid = r_vld[2];

endmodule

// File: tb/tb_fir_guide.sv
// Scoreboard bench for fir_guide: model pushes expected yout on each accepted
// sample, DUT outputs are popped and compared on every valid cycle.
module tb_fir_guide;

  logic        clk;
  logic        rstn;
  logic        en;
  logic [11:0] xin;
  logic        valid;
  logic [28:0] yout;

  fir_guide u_dut (
    .clk  (clk),
    .rstn (rstn),
    .en   (en),
    .xin  (xin),
    .valid(valid),
    .yout (yout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int unsigned h [8] = '{11, 31, 63, 104, 152, 198, 235, 255};
  int unsigned m_tap [16];
  int unsigned q [$];
  bit          hist [4];
  int unsigned last_y;
  int unsigned tone [200];
  int          errors;
  int          checks;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic int unsigned model_y();
    int unsigned s;
    s = 0;
    for (int k = 0; k < 16; k++)
      s += ((k < 8) ? h[k] : h[15-k]) * m_tap[k];
    return s;
  endfunction

  task automatic cyc(input bit e, input int unsigned x);
    int unsigned exp_y;
    @(negedge clk);
    chk("valid", {31'd0, valid}, {31'd0, hist[3]});
    if (valid) begin
      if (q.size() == 0) begin
        chk("q_underflow", 32'd1, 32'd0);
      end else begin
        exp_y = q.pop_front();
        chk("yout", {3'd0, yout}, exp_y);
        last_y = exp_y;
      end
    end else begin
      chk("hold", {3'd0, yout}, last_y);
    end
    for (int i = 3; i > 0; i--) hist[i] = hist[i-1];
    hist[0] = e;
    en  = e;
    xin = x[11:0];
    if (e) begin
      for (int i = 15; i > 0; i--) m_tap[i] = m_tap[i-1];
      m_tap[0] = x & 32'hfff;
      q.push_back(model_y());
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rstn = 1'b1;
    q.delete();
    for (int i = 0; i < 16; i++) m_tap[i] = 0;
    for (int i = 0; i < 4; i++) hist[i] = 1'b0;
    last_y = 0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("rst_valid", {31'd0, valid}, 32'd0);
      chk("rst_yout", {3'd0, yout}, 32'd0);
      en  = 1'b1;
      xin = (i % 2 == 0) ? 12'hfff : 12'h5a5;
    end
    @(negedge clk);
    rstn = 1'b0;
    en   = 1'b0;
    xin  = '0;
  endtask

  initial begin
    real r;
    errors = 0;
    checks = 0;
    rstn   = 1'b1;
    en     = 1'b0;
    xin    = '0;
    for (int n = 0; n < 200; n++) begin
      r = 2048.0 + 1100.0 * $cos(2.0 * 3.14159265358979 * n / 200.0)
                 +  800.0 * $cos(2.0 * 3.14159265358979 * 3.0 * n / 20.0);
      tone[n] = $rtoi(r + 0.5);
    end

    do_reset();

    // impulse
    cyc(1'b1, 1);
    for (int i = 0; i < 20; i++) cyc(1'b1, 0);

    // DC full scale
    for (int i = 0; i < 24; i++) cyc(1'b1, 4095);
    for (int i = 0; i < 5; i++) cyc(1'b0, 0);
    chk("dc_full", {3'd0, yout}, 32'd8591310);

    // en gap pattern 1,1,0,0,1
    cyc(1'b1, 100);
    cyc(1'b1, 200);
    cyc(1'b0, 999);
    cyc(1'b0, 999);
    cyc(1'b1, 300);
    for (int i = 0; i < 6; i++) cyc(1'b0, 0);

    // mixed tone with occasional gaps, reset mid-stream at cycle 500
    for (int n = 0; n < 2000; n++) begin
      if (n == 500) do_reset();
      cyc((n % 17) != 5, tone[n % 200]);
    end
    for (int i = 0; i < 6; i++) cyc(1'b0, 0);
    chk("q_empty", q.size(), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/fir_guide.md
FIR_GUIDE -- requirements
Module: fir_guide

Interface
REQ-001 SHALL have no module parameters; all constants come from the shared package.
REQ-002 clk  input  1  single rising-edge clock for all state.
REQ-003 rstn  input  1  reset, asynchronous, active-high (despite the name); all registers clear while rstn=1.
REQ-004 en  input  1  sample strobe; xin is accepted on a clk rising edge where en=1.
REQ-005 xin  input  12  input sample, unsigned binary.
REQ-006 valid  output  1  yout qualifier.
REQ-007 yout  output  29  filter output, unsigned.

Function
REQ-008 SHALL implement a 16-tap linear-phase FIR: y[n] = sum over k=0..15 of h[k]*x[n-k].
- h[k] = h[15-k].
- h[0..7] = 11, 31, 63, 104, 152, 198, 235, 255 (12-bit unsigned).
REQ-009 SHALL hold a 16-entry 12-bit tap shift register.
- On each edge with en=1, xin enters tap0 and every tap shifts by one.
- With en=0, taps hold.
REQ-010 Stage 1 SHALL register the 8 symmetric pre-sums tap[k]+tap[15-k] at 13 bits each, with no truncation.
REQ-011 Stage 2 SHALL register the 8 products pre-sum[k]*h[k] at 25 bits each.
REQ-012 Stage 3 SHALL register the sum of the 8 products, zero-extended to 29 bits, into yout.
- Maximum value is 8,591,310, so overflow cannot occur.
REQ-013 Stages 1-3 SHALL run every clock regardless of en.
- yout reflects the current tap contents.
- yout stays constant while en=0.
REQ-014 Latency SHALL be 3 clocks: a sample taken at edge k affects yout from edge k+3.
REQ-015 valid SHALL equal en delayed by exactly 3 clocks, through a 3-bit register pipeline.
REQ-016 Gaps in en SHALL produce matching gaps in valid, 3 clocks later; no other handshake.
REQ-017 After reset, the first 15 valid outputs include zero history (taps cleared); no warm-up suppression.

Reset
REQ-018 rstn=1 SHALL asynchronously clear:
- all taps, pre-sums, products and the en delay pipeline;
- yout to 0 and valid to 0.
REQ-019 Reset mid-stream SHALL discard all history.
- After release, output restarts as if the filter were fresh.
- valid stays 0 until 3 clocks after the first post-reset en=1.

Configuration
REQ-020 Macro FIR_PREADD_EN defined: symmetric pre-adder structure as in REQ-010/011, using 8 multipliers.
REQ-021 Macro FIR_PREADD_EN undefined:
- stage 1 registers the 16 taps directly.
- stage 2 forms 16 products tap[k]*h[k] (24 bits each).
- stage 3 sums the 16 products.
- yout, valid and latency are bit- and cycle-identical to the defined case.

Structure
REQ-022 Package fir_guide_pkg SHALL contain:
- NTAPS=16, NHALF=8, IN_W=12, COEF_W=12, SUM_W=13, PROD_W=25, OUT_W=29;
- the 8-entry coefficient constant array.
REQ-023 One sub-module, fir_guide_mult, SHALL implement a registered unsigned multiplier (async active-high reset).
- It is instantiated 8 times (FIR_PREADD_EN) or 16 times (otherwise).

Verification
REQ-024 Reset: hold rstn=1 with en=1 and xin toggling -> yout=0 and valid=0 throughout; taps unchanged.
REQ-025 Impulse: xin=1 for one en cycle, then xin=0 with en=1 -> starting 3 clocks after the impulse, yout = 11,31,63,104,152,198,235,255,255,235,198,152,104,63,31,11, then 0.
REQ-026 DC: xin=4095 held with en=1 -> yout ramps, then from the 16th sample +3 clocks holds 8,591,310 (the full-scale maximum); valid=1 continuously.
REQ-027 en gaps: en pattern 1,1,0,0,1 -> valid shows 1,1,0,0,1 delayed 3 clocks; yout frozen during the gap; no sample lost or duplicated.
REQ-028 Mixed-tone stimulus: 200-sample 12-bit 250 kHz + 7.5 MHz cosine at 50 MHz sample rate, looped for 2000 cycles -> yout matches a bit-exact golden model every valid cycle.
- 7.5 MHz component visibly attenuated; 250 kHz component passes.
REQ-029 Reset mid-stream at cycle 500 -> next valid outputs match the golden model restarted from zero history; run in both FIR_PREADD_EN configurations.
